instr_prefetch_buffer: RTL and testbench
========================================

# instr_prefetch_buffer

- Sits directly upstream of the fetch stage, between an external instruction memory and the pipeline.
- Issues sequential word fetches over a request/acknowledge handshake that tolerates variable latency, and buffers returned instructions in a small FIFO.
- Presents the head instruction and its PC to the fetch stage.
- Honours fetch stalls from the hazard unit and flushes/redirects on taken branches resolved in execute.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- stallF  in  1  fetch stage holding; head must not be consumed.
- PCSrcE  in  1  taken branch/redirect from execute.
- PCTargetE  in  32  redirect target; only meaningful when PCSrcE=1.
- InstrF  out  32  head instruction; 32'h0000_0013 (NOP) when validF=0.
- PCF  out  32  PC of head entry; equals next fetch PC when empty.
- validF  out  1  head entry valid.
- imem_req  out  1  memory request, registered.
- imem_addr  out  32  word address of request, registered, low 2 bits always 0.
- imem_ack  in  1  transfer completes this cycle when imem_req=1.
- imem_rdata  in  32  instruction data, valid with imem_ack.

## Operation
- Pop condition: validF & ~stallF & ~PCSrcE. On pop, the head entry advances.
- FIFO: read and write pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- On every accepted, non-stale ack, an entry {imem_rdata, imem_addr} is written to the FIFO.
- fetch_pc register: address of the next request, incremented by 4 on each accepted ack (32-bit wrap).
- State machine:
  - IDLE: imem_req=0. Go to REQ when count<DEPTH.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On ack: write the entry.
    - Then stay in REQ if the post-update count is <DEPTH, else go to IDLE.
  - DRAIN: imem_req=1 held at the stale address. On ack, data is discarded and the state goes to REQ with the new fetch_pc.
- Handshake rule: once imem_req rises, imem_req and imem_addr stay stable until the ack cycle. A request is never withdrawn.
- Redirect (PCSrcE=1) takes priority over pop and write:
  - FIFO cleared (pointers and count set to 0), fetch_pc set to PCTargetE.
  - In REQ with no ack this cycle: go to DRAIN.
  - In REQ with ack this cycle: data discarded, go to REQ.
  - In IDLE: go to REQ.
  - In DRAIN: stay in DRAIN and update fetch_pc.
- Simultaneous pop and write at any count: count is unchanged.
- A full FIFO is impossible at ack, because a request is only issued when count<DEPTH and there is a single outstanding request.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE, count 0, fetch_pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - validF=0, InstrF=32'h0000_0013, PCF=RESET_PC.
- First imem_req rises on the first rising edge after rst deasserts.
- Ack-to-visible latency: 1 cycle. An ack at edge t makes validF=1 after edge t.
- Back-to-back: a zero-wait memory sustains one instruction per cycle.
- Redirect to first new request: the request for PCTargetE is presented in the cycle after the redirect edge, or after the DRAIN ack.
- Reset mid-transfer: the outstanding transfer is abandoned. The memory side must tolerate req dropping.

## Configuration
- PREFETCH_BYPASS_EN defined:
  - When the FIFO is empty and a non-stale ack arrives, imem_rdata and imem_addr drive InstrF/PCF with validF=1 combinationally in the same cycle.
  - If popped that cycle, the entry is not written.
  - This adds a combinational path from imem_ack/imem_rdata to validF/InstrF.
- Undefined: all data passes through the FIFO. Ack-to-visible latency is always 1 cycle, and outputs depend only on registers.

## Test plan
1. **Sequential fetch:** release reset, zero-wait memory (ack whenever req), stallF=0 → imem_addr sequence 0x0, 0x4, 0x8, ...; validF=1 from the second cycle; PCF tracks 0x0, 0x4, 0x8, one per cycle.
2. **Fill under stall:** stallF=1, zero-wait memory, DEPTH=4 → four acks (0x0–0xC), then imem_req=0 with PCF stuck at 0x0. Release stallF → PCF 0x0, 0x4, 0x8, 0xC on consecutive cycles; req resumes at 0x10.
3. **Redirect on ack:** PCSrcE=1, PCTargetE=0x100 in the ack cycle of 0x8 → data for 0x8 discarded, validF=0 next cycle, next imem_addr=0x100, then PCF=0x100.
4. **Redirect while pending:** ack delay 3 cycles, redirect to 0x200 while the request for 0x20 is pending → imem_addr stays 0x20 until ack, its data is never visible, then a request at 0x200.
5. **Async reset mid-transfer:** assert rst between edges while req=1 with 2 entries buffered → imem_req=0, validF=0, PCF=0x0 without waiting for a clock edge.
6. **Bypass (PREFETCH_BYPASS_EN):** empty FIFO, ack with imem_rdata=0x0050_0093 at addr 0x40 → validF=1, InstrF=0x0050_0093, PCF=0x40 in the same cycle. With stallF=0 the count stays 0.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding req/ack fetch feeding a DEPTH-entry FIFO; 1-cycle ack-to-head latency,
// stallF holds the head, PCSrcE flushes and redirects. Define PREFETCH_BYPASS_EN for same-cycle ack-to-head bypass when empty.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        validF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [31:0]      fetch_pc, fetch_pc_nxt, addr_nxt;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             fifo_valid, ack_ok, pop, pop_fifo, wr_en;

  assign fifo_valid = (count != '0);
  // Only an ack for a live (non-DRAIN) request that is not being flushed carries usable data.
  assign ack_ok     = (state == REQ) && imem_req && imem_ack && !PCSrcE;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass = !fifo_valid && ack_ok;
  assign validF = fifo_valid || bypass;
  assign InstrF = fifo_valid ? instr_mem[rd_ptr] : (bypass ? imem_rdata : NOP);
  assign PCF    = fifo_valid ? pc_mem[rd_ptr]    : (bypass ? imem_addr  : fetch_pc);
  assign pop    = validF && !stallF && !PCSrcE;
  assign wr_en  = ack_ok && !(bypass && pop);
`else
  assign validF = fifo_valid;
  assign InstrF = fifo_valid ? instr_mem[rd_ptr] : NOP;
  assign PCF    = fifo_valid ? pc_mem[rd_ptr]    : fetch_pc;
  assign pop    = validF && !stallF && !PCSrcE;
  assign wr_en  = ack_ok;
`endif

  assign pop_fifo = pop && fifo_valid;

  always_comb begin
    count_nxt = count;
    case ({wr_en, pop_fifo})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (PCSrcE)
      fetch_pc_nxt = PCTargetE & ~32'h3;
    else if (ack_ok)
      fetch_pc_nxt = fetch_pc + 32'd4;

    case (state)
      IDLE: begin
        if (PCSrcE || (count < DEPTH_C))
          state_nxt = REQ;
      end
      REQ: begin
        if (PCSrcE)
          state_nxt = imem_ack ? REQ : DRAIN;
        else if (imem_ack && (count_nxt >= DEPTH_C))
          state_nxt = IDLE;
      end
      DRAIN: begin
        if (imem_ack)
          state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase

    // A stale request keeps its address on the bus until the memory acknowledges it.
    addr_nxt = (state_nxt == DRAIN) ? imem_addr : fetch_pc_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      imem_req  <= (state_nxt != IDLE);
      imem_addr <= addr_nxt;
      if (PCSrcE) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_fifo)
          rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= imem_addr;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer (DEPTH=4, RESET_PC=0); memory returns addr+0x1000_0000 as instruction data.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        validF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        auto_ack;
  logic        manual_ack;
  logic        use_ovr;
  logic [31:0] ovr_data;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .validF     (validF),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req & (auto_ack | manual_ack);
  assign imem_rdata = use_ovr ? ovr_data : (imem_addr + 32'h1000_0000);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    stallF     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = 32'h0;
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    use_ovr    = 1'b0;
    ovr_data   = 32'h0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    stallF     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = 32'h0;
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    use_ovr    = 1'b0;
    ovr_data   = 32'h0;

    // Reset values
    #3;
    check("rst_req",   {31'b0, imem_req}, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'b0, validF}, 32'h0);
    check("rst_instr", InstrF, NOP);
    check("rst_pc",    PCF, 32'h0);

    // Sequential fetch, zero-wait memory
    do_reset();
    auto_ack = 1'b1;
    tick();
    check("seq_req1",   {31'b0, imem_req}, 32'h1);
    check("seq_addr1",  imem_addr, 32'h0);
    check("seq_valid1", {31'b0, validF}, 32'h0);
    tick();
    check("seq_valid2", {31'b0, validF}, 32'h1);
    check("seq_pc2",    PCF, 32'h0);
    check("seq_instr2", InstrF, 32'h1000_0000);
    check("seq_addr2",  imem_addr, 32'h4);
    tick();
    check("seq_pc3",    PCF, 32'h4);
    check("seq_addr3",  imem_addr, 32'h8);
    tick();
    check("seq_pc4",    PCF, 32'h8);
    check("seq_instr4", InstrF, 32'h1000_0008);

    // Fill under stall, then drain
    do_reset();
    stallF   = 1'b1;
    auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fill_addr", imem_addr, 32'(i * 4));
    end
    tick();
    check("fill_req_off", {31'b0, imem_req}, 32'h0);
    check("fill_pc",      PCF, 32'h0);
    tick();
    check("fill_req_off2", {31'b0, imem_req}, 32'h0);
    check("fill_pc2",      PCF, 32'h0);
    stallF = 1'b0;
    tick();
    check("drain_pc1", PCF, 32'h4);
    tick();
    check("drain_pc2",   PCF, 32'h8);
    check("drain_req",   {31'b0, imem_req}, 32'h1);
    check("drain_addr",  imem_addr, 32'h10);
    tick();
    check("drain_pc3", PCF, 32'hC);
    tick();
    check("drain_pc4",   PCF, 32'h10);
    check("drain_instr", InstrF, 32'h1000_0010);

    // Redirect in the ack cycle of 0x8
    do_reset();
    auto_ack = 1'b1;
    tick();
    tick();
    tick();
    check("redir_addr8", imem_addr, 32'h8);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0;
    check("redir_valid0", {31'b0, validF}, 32'h0);
    check("redir_instr0", InstrF, NOP);
    check("redir_addr",   imem_addr, 32'h100);
    tick();
    check("redir_valid1", {31'b0, validF}, 32'h1);
    check("redir_pc",     PCF, 32'h100);
    check("redir_instr",  InstrF, 32'h1000_0100);

    // Redirect while a slow request is pending
    do_reset();
    PCSrcE    = 1'b1;
    PCTargetE = 32'h20;
    tick();
    PCSrcE = 1'b0;
    check("pend_addr1", imem_addr, 32'h20);
    tick();
    PCSrcE    = 1'b1;
    PCTargetE = 32'h200;
    tick();
    PCSrcE = 1'b0;
    check("pend_hold1", imem_addr, 32'h20);
    check("pend_req1",  {31'b0, imem_req}, 32'h1);
    check("pend_val1",  {31'b0, validF}, 32'h0);
    tick();
    check("pend_hold2", imem_addr, 32'h20);
    manual_ack = 1'b1;
    tick();
    manual_ack = 1'b0;
    check("pend_newaddr", imem_addr, 32'h200);
    check("pend_val2",    {31'b0, validF}, 32'h0);
    tick();
    check("pend_val3", {31'b0, validF}, 32'h0);
    manual_ack = 1'b1;
    tick();
    manual_ack = 1'b0;
    check("pend_val4",  {31'b0, validF}, 32'h1);
    check("pend_pc",    PCF, 32'h200);
    check("pend_instr", InstrF, 32'h1000_0200);

    // Asynchronous reset mid-transfer with two entries buffered
    do_reset();
    stallF   = 1'b1;
    auto_ack = 1'b1;
    tick();
    tick();
    tick();
    check("areset_pre_req", {31'b0, imem_req}, 32'h1);
    check("areset_pre_val", {31'b0, validF}, 32'h1);
    auto_ack = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("areset_req",   {31'b0, imem_req}, 32'h0);
    check("areset_valid", {31'b0, validF}, 32'h0);
    check("areset_pc",    PCF, 32'h0);
    check("areset_instr", InstrF, NOP);

`ifdef PREFETCH_BYPASS_EN
    // Same-cycle bypass on an empty FIFO
    do_reset();
    PCSrcE    = 1'b1;
    PCTargetE = 32'h40;
    tick();
    PCSrcE   = 1'b0;
    use_ovr  = 1'b1;
    ovr_data = 32'h0050_0093;
    manual_ack = 1'b1;
    #1;
    check("byp_valid", {31'b0, validF}, 32'h1);
    check("byp_instr", InstrF, 32'h0050_0093);
    check("byp_pc",    PCF, 32'h40);
    tick();
    manual_ack = 1'b0;
    check("byp_empty", {31'b0, validF}, 32'h0);
    check("byp_addr",  imem_addr, 32'h44);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
